// File: rtl/three_phase_pkg.sv
// Shared definitions for the three_phase generator family: default omega width
// and the ramp controller's FSM state encoding (also visible on its debug port).
package three_phase_pkg;

  localparam int OMEGA_BW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_HOLD = 2'd2,
    ST_STOP = 2'd3
  } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that pulses tick once every TICK_DIV clocks while run is
// high; restart or !run forces the count back to zero.
module tick_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int CNT_BW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_BW-1:0] LAST = CNT_BW'(TICK_DIV - 1);

  logic [CNT_BW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (restart || !run) begin
      count_d = '0;
    end else if (count_q == LAST) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A restart on the wrap cycle swallows that tick so the new period is a full one.
  assign tick = run && !restart && (count_q == LAST);

endmodule

// File: rtl/omega_ramp_ctrl.sv
// Soft-start/soft-stop scheduler: slews omega toward an accepted signed target by
// at most step per prescaler tick, and ramps to zero when en drops.
module omega_ramp_ctrl
  import three_phase_pkg::*;
#(
  parameter int OMEGA_BW = OMEGA_BW_DEF,
  parameter int STEP_BW  = 16,
  parameter int TICK_DIV = 1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic signed [OMEGA_BW-1:0] target_omega,
  input  logic                       target_valid,
  output logic                       target_ready,
  input  logic        [STEP_BW-1:0]  step,
  output logic signed [OMEGA_BW-1:0] omega,
  output logic                       at_target,
  output logic        [1:0]          state_o
);

  localparam int CW = OMEGA_BW + STEP_BW + 2;

  state_t                     state_q, state_d;
  logic signed [OMEGA_BW-1:0] omega_q, omega_d;
  logic signed [OMEGA_BW-1:0] target_q, target_d;
  logic                       ready_q, ready_d;
  logic                       accept, run, tick, slew_en;
  logic signed [CW-1:0]       goal_x, omega_x, step_x, diff_x, mag_x, slewed_x;
  logic                       unused_slew_hi;

  // Handshake: a target transfers on a rising edge where target_valid and
  // target_ready are both high; ready is a registered copy of "next state != STOP".
  assign accept = target_valid && ready_q;
  assign run    = (state_q == ST_RAMP) || (state_q == ST_STOP);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .restart (accept),
    .tick    (tick)
  );

  // Wide signed arithmetic so goal-omega and omega+-step can never wrap.
  always_comb begin
    goal_x  = (state_q == ST_RAMP) ? {{(CW-OMEGA_BW){target_q[OMEGA_BW-1]}}, target_q} : '0;
    omega_x = {{(CW-OMEGA_BW){omega_q[OMEGA_BW-1]}}, omega_q};
    step_x  = {{(CW-STEP_BW){1'b0}}, step};
    diff_x  = goal_x - omega_x;
    mag_x   = diff_x[CW-1] ? -diff_x : diff_x;
    if (mag_x <= step_x) begin
      slewed_x = goal_x;
    end else if (diff_x[CW-1]) begin
      slewed_x = omega_x - step_x;
    end else begin
      slewed_x = omega_x + step_x;
    end
  end

  assign unused_slew_hi = ^slewed_x[CW-1:OMEGA_BW];

  // STOP keeps ramping down even if en comes back; RAMP only moves while enabled.
  assign slew_en = tick && ((state_q == ST_STOP) || ((state_q == ST_RAMP) && en));

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    omega_d  = slew_en ? slewed_x[OMEGA_BW-1:0] : omega_q;
    if (accept) begin
      target_d = target_omega;
    end
    case (state_q)
      ST_IDLE: begin
        if (en && accept) state_d = ST_RAMP;
      end
      ST_RAMP: begin
        if (!en)                       state_d = ST_STOP;
        else if (accept)               state_d = ST_RAMP;
        else if (omega_d == target_q)  state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!en)                                      state_d = ST_STOP;
        else if (accept && (target_omega != target_q)) state_d = ST_RAMP;
      end
      ST_STOP: begin
        if (omega_d == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d != ST_STOP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      omega_q  <= '0;
      target_q <= '0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      omega_q  <= omega_d;
      target_q <= target_d;
      ready_q  <= ready_d;
    end
  end

  assign omega        = omega_q;
  assign target_ready = ready_q;
  assign at_target    = (state_q == ST_HOLD) && (omega_q == target_q);
  assign state_o      = state_q;

endmodule
